clint_axi_peripheral_bridge: RTL and testbench
==============================================

Name: clint_axi_peripheral_bridge

Overview:
- Parametrised successor to the single-hart CPU-to-peripheral AXI master.
- Bridges the core's uncached peripheral port (64-bit, word or doubleword) onto an AXI4-Lite master of configurable data width.
- Contains an N-hart CLINT: mtime with configurable prescaler, per-hart mtimecmp and msip.
- Adds response-error reporting and a bus-hang timeout.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32: AXI address width.
- C_M_AXI_DATA_WIDTH, 32: AXI data width; 32 or 64.
- CPU_DATA_WIDTH, 64: peripheral-port data width. BEATS = CPU_DATA_WIDTH/C_M_AXI_DATA_WIDTH, which is 1 or 2.
- CLINT_BASE, 32'h0200_0000: CLINT base address. The CLINT window is 64 KiB.
- N_HARTS, 1: number of harts, 1..4.
- MTIME_DIV, 8: clock cycles per mtime increment, ≥1.
- TIMEOUT_CYCLES, 1023: maximum wait cycles on any AXI channel; 0 disables the timeout.

Ports:
- M_AXI_ACLK  in  1  clock.
- M_AXI_ARESET  in  1  asynchronous active-high reset.
- ADDR_TO_PERI_VALID  in  1  request strobe; sampled only in IDLE.
- ADDR_TO_PERI  in  64  byte address; held by the core until ready.
- DATA_TO_PERI  in  CPU_DATA_WIDTH  write data, lane-aligned.
- WSTRB  in  CPU_DATA_WIDTH/8  write byte strobes.
- WRITE_TO_PERI  in  1  1 = write.
- PERI_WORD_ACCESS  in  1  1 = 32-bit access, 0 = 64-bit access.
- DATA_FROM_PERI_READY  out  1  one-cycle completion pulse.
- DATA_FROM_PERI  out  CPU_DATA_WIDTH  read data; valid with READY.
- PERI_ERROR  out  1  valid with READY: SLVERR/DECERR response or timeout.
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARPROT/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master channels. PROT is tied to 0.
- MTIP  out  N_HARTS  machine timer interrupt, per hart.
- MSIP  out  N_HARTS  machine software interrupt, per hart.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - Every output is 0, including all VALID/READY signals; in-flight AXI transactions are abandoned.
  - mtime = 0, prescaler = 0, mtimecmp[h] = all-ones, msip = 0, state = IDLE.
- CLINT decode, for addresses with addr − CLINT_BASE < 0x10000:
  - msip[h] at +4h: bit 0 only.
  - mtimecmp[h] at +0x4000 + 8h.
  - mtime at +0xBFF8.
  - Any other address in the window reads 0; writes to it are ignored.
- CLINT accesses:
  - READY the cycle after acceptance; no AXI activity; PERI_ERROR = 0.
  - Writes honour WSTRB per byte.
  - A word access uses lane ADDR[2]. Read data is placed on that lane; the other lane returns 0.
- Timer:
  - The prescaler counts 0..MTIME_DIV−1; mtime increments by 1 on wrap.
  - A CPU write to mtime in the same cycle as an increment: the write wins, and the prescaler resets to 0.
  - MTIP[h] is registered: mtime ≥ mtimecmp[h] (unsigned, 64-bit), so it updates one cycle after either register changes.
  - MSIP[h] = msip[h].
- AXI path, all other addresses. States: IDLE → ADDR (AR, or AW+W together) → RESP (R or B) → next beat or DONE → IDLE.
- Beat plan:
  - Word access: 1 beat at ADDR.
  - Doubleword access: BEATS beats. Beat k address = (ADDR & ~(CPU_DATA_WIDTH/8−1)) + k·C_M_AXI_DATA_WIDTH/8.
  - For writes, beats whose strobe slice is all-zero are skipped. If every beat is skipped, the access completes with READY next cycle.
- Handshakes:
  - AWVALID and WVALID assert together and drop independently on their own handshakes.
  - The bridge enters RESP only after both handshakes are done.
  - BREADY and RREADY are held high throughout RESP.
  - Read data is captured on the R handshake into the beat's lane.
- Errors:
  - A nonzero RRESP or BRESP aborts the remaining beats. The access completes with PERI_ERROR = 1, and DATA_FROM_PERI holds the lanes captured so far.
- Timeout:
  - A counter runs in ADDR and RESP and clears on each handshake.
  - On reaching TIMEOUT_CYCLES, all VALID/READY signals deassert and the access completes with PERI_ERROR = 1 (a deliberate recovery deviation from AXI).
- Completion:
  - DATA_FROM_PERI_READY is high for exactly one cycle. DATA_FROM_PERI and PERI_ERROR are valid in that cycle and cleared to 0 the next cycle.
  - ADDR_TO_PERI_VALID outside IDLE is ignored; there is no queueing.
  - A new request is accepted earliest the cycle after READY.
- Latency, zero-wait slave: word read = 3 cycles from acceptance to READY; doubleword read = 5 cycles.

Test Plan:
- CLINT write/read: write mtimecmp[0] = 64'h100, then read it back → 64'h100, READY 1 cycle after request. With MTIME_DIV = 8, MTIP[0] rises at cycle 8·256 + 1 after reset, ±1.
- Doubleword read, 32-bit AXI: slave returns 32'hDEADBEEF @0x1000_0000 and 32'hCAFEF00D @0x1000_0004 → DATA_FROM_PERI = 64'hCAFEF00D_DEADBEEF, two AR handshakes, PERI_ERROR = 0.
- Write with WSTRB = 8'hF0 to 0x1000_0000, doubleword → a single AW at 0x1000_0004 with WSTRB 4'hF and WDATA = DATA_TO_PERI[63:32].
- Slave returns BRESP = 2'b10 on beat 0 of a doubleword write → no second AW; READY and PERI_ERROR = 1 in the same cycle.
- ARREADY held low, TIMEOUT_CYCLES = 15 → ARVALID drops and READY + PERI_ERROR pulse 15 cycles after ARVALID rose. The next request is serviced normally.
- msip[1] write 1 with N_HARTS = 2 → MSIP = 2'b10. Assert reset mid-AXI read → ARVALID = 0 immediately, MSIP = 0, mtime = 0.

Source files
------------

// File: rtl/clint_axi_peripheral_bridge.sv
// Peripheral-port to AXI4-Lite master bridge with an N-hart CLINT (mtime/mtimecmp/msip),
// response-error reporting and a per-channel bus-hang timeout.
module clint_axi_peripheral_bridge #(
    parameter int          C_M_AXI_ADDR_WIDTH = 32,
    parameter int          C_M_AXI_DATA_WIDTH = 32,
    parameter int          CPU_DATA_WIDTH     = 64,
    parameter logic [31:0] CLINT_BASE         = 32'h0200_0000,
    parameter int          N_HARTS            = 1,
    parameter int          MTIME_DIV          = 8,
    parameter int          TIMEOUT_CYCLES     = 1023
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESET,
    input  logic                            ADDR_TO_PERI_VALID,
    input  logic [63:0]                     ADDR_TO_PERI,
    input  logic [CPU_DATA_WIDTH-1:0]       DATA_TO_PERI,
    input  logic [CPU_DATA_WIDTH/8-1:0]     WSTRB,
    input  logic                            WRITE_TO_PERI,
    input  logic                            PERI_WORD_ACCESS,
    output logic                            DATA_FROM_PERI_READY,
    output logic [CPU_DATA_WIDTH-1:0]       DATA_FROM_PERI,
    output logic                            PERI_ERROR,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY,
    output logic [N_HARTS-1:0]              MTIP,
    output logic [N_HARTS-1:0]              MSIP
);

    localparam int AXI_B  = C_M_AXI_DATA_WIDTH / 8;
    localparam int CPU_B  = CPU_DATA_WIDTH / 8;
    localparam int BEATS  = CPU_DATA_WIDTH / C_M_AXI_DATA_WIDTH;
    localparam int SLOT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PRE_W  = (MTIME_DIV > 1) ? $clog2(MTIME_DIV) : 1;
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_RESP, S_DONE} state_t;

    state_t state_q, state_d;

    logic [63:0]             mtime_q, mtime_d;
    logic [PRE_W-1:0]        presc_q, presc_d;
    logic [63:0]             mtimecmp_q [N_HARTS];
    logic [63:0]             mtimecmp_d [N_HARTS];
    logic [N_HARTS-1:0]      msip_q, msip_d, mtip_q;

    logic [63:0]             clint_off;
    logic [15:0]             off;
    logic                    in_clint, clint_wr;
    logic [63:0]             clint_rdata;

    logic [C_M_AXI_ADDR_WIDTH-1:0] req_addr_q, aligned_addr, beat_addr;
    logic [CPU_DATA_WIDTH-1:0]     req_data_q, rdata_q;
    logic [CPU_B-1:0]              req_strb_q;
    logic                          req_write_q, req_word_q;
    logic [BEATS-1:0]              mask_q, req_mask, slot_onehot, mask_rest;
    logic [SLOT_W-1:0]             slot;
    logic                          aw_done_q, w_done_q, err_q;
    logic [31:0]                   tmo_q;
    logic [C_M_AXI_DATA_WIDTH-1:0] beat_wdata;
    logic [AXI_B-1:0]              beat_wstrb;
    logic aw_hs, w_hs, ar_hs, resp_hs, resp_err, any_hs, addr_done, tmo_hit;

    assign clint_off = ADDR_TO_PERI - 64'(CLINT_BASE);
    assign in_clint  = clint_off < 64'h1_0000;
    assign off       = clint_off[15:0];
    assign clint_wr  = (state_q == S_IDLE) && ADDR_TO_PERI_VALID && in_clint && WRITE_TO_PERI;

    // Both 32-bit lanes of the addressed doubleword are decoded; a word access keeps only lane ADDR[2].
    always_comb begin : clint_read
        logic [15:0] wa;
        logic [31:0] wv;
        clint_rdata = '0;
        for (int unsigned l = 0; l < 2; l++) begin
            wa = {off[15:3], l[0], 2'b00};
            wv = '0;
            for (int unsigned h = 0; h < N_HARTS; h++) begin
                if (wa == 16'(4 * h))             wv = {31'b0, msip_q[h]};
                if (wa == 16'(32'h4000 + 8 * h))  wv = mtimecmp_q[h][31:0];
                if (wa == 16'(32'h4004 + 8 * h))  wv = mtimecmp_q[h][63:32];
            end
            if (wa == 16'hBFF8) wv = mtime_q[31:0];
            if (wa == 16'hBFFC) wv = mtime_q[63:32];
            if (PERI_WORD_ACCESS && (l[0] != off[2])) wv = '0;
            clint_rdata[32*l +: 32] = wv;
        end
    end

    // CPU writes are applied after the prescaler increment so a same-cycle mtime write wins.
    always_comb begin : clint_write
        logic [15:0] wa;
        logic [31:0] wb;
        logic [3:0]  ws;
        mtime_d = mtime_q;
        presc_d = presc_q;
        msip_d  = msip_q;
        for (int unsigned h = 0; h < N_HARTS; h++) mtimecmp_d[h] = mtimecmp_q[h];
        if (presc_q == PRE_W'(MTIME_DIV - 1)) begin
            presc_d = '0;
            mtime_d = mtime_q + 64'd1;
        end else begin
            presc_d = presc_q + PRE_W'(1);
        end
        for (int unsigned l = 0; l < 2; l++) begin
            wa = {off[15:3], l[0], 2'b00};
            wb = DATA_TO_PERI[32*l +: 32];
            ws = WSTRB[4*l +: 4];
            if (clint_wr && (!PERI_WORD_ACCESS || (l[0] == off[2]))) begin
                for (int unsigned h = 0; h < N_HARTS; h++) begin
                    if ((wa == 16'(4 * h)) && ws[0]) msip_d[h] = wb[0];
                    for (int unsigned b = 0; b < 4; b++) begin
                        if (ws[b] && (wa == 16'(32'h4000 + 8 * h))) mtimecmp_d[h][8*b +: 8]      = wb[8*b +: 8];
                        if (ws[b] && (wa == 16'(32'h4004 + 8 * h))) mtimecmp_d[h][32+8*b +: 8]   = wb[8*b +: 8];
                    end
                end
                for (int unsigned b = 0; b < 4; b++) begin
                    if (ws[b] && (wa == 16'hBFF8)) mtime_d[8*b +: 8]    = wb[8*b +: 8];
                    if (ws[b] && (wa == 16'hBFFC)) mtime_d[32+8*b +: 8] = wb[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            mtime_q <= '0;
            presc_q <= '0;
            msip_q  <= '0;
            mtip_q  <= '0;
            for (int unsigned h = 0; h < N_HARTS; h++) mtimecmp_q[h] <= '1;
        end else begin
            mtime_q <= mtime_d;
            presc_q <= presc_d;
            msip_q  <= msip_d;
            for (int unsigned h = 0; h < N_HARTS; h++) begin
                mtimecmp_q[h] <= mtimecmp_d[h];
                mtip_q[h]     <= (mtime_q >= mtimecmp_q[h]);
            end
        end
    end

    // Beat plan: one mask bit per AXI-width slot still to be transferred; the lowest set bit is current.
    always_comb begin : beat_plan
        logic found;
        req_mask = '0;
        for (int unsigned i = 0; i < BEATS; i++) begin
            req_mask[i] = (!PERI_WORD_ACCESS || (BEATS == 1) || (i[0] == ADDR_TO_PERI[2]))
                          && (!WRITE_TO_PERI || (|WSTRB[i*AXI_B +: AXI_B]));
        end
        slot  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < BEATS; i++) begin
            if (mask_q[i] && !found) begin
                slot  = SLOT_W'(i);
                found = 1'b1;
            end
        end
        slot_onehot  = BEATS'(1) << slot;
        mask_rest    = mask_q & ~slot_onehot;
        aligned_addr = req_addr_q & ~C_M_AXI_ADDR_WIDTH'(CPU_B - 1);
        beat_addr    = req_word_q ? req_addr_q
                                  : aligned_addr + C_M_AXI_ADDR_WIDTH'(32'(slot) * 32'(AXI_B));
        beat_wdata   = req_data_q[slot*C_M_AXI_DATA_WIDTH +: C_M_AXI_DATA_WIDTH];
        beat_wstrb   = req_strb_q[slot*AXI_B +: AXI_B];
    end

    assign aw_hs     = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs      = M_AXI_WVALID && M_AXI_WREADY;
    assign ar_hs     = M_AXI_ARVALID && M_AXI_ARREADY;
    assign resp_hs   = (M_AXI_BREADY && M_AXI_BVALID) || (M_AXI_RREADY && M_AXI_RVALID);
    assign resp_err  = req_write_q ? (M_AXI_BRESP != 2'b00) : (M_AXI_RRESP != 2'b00);
    assign any_hs    = aw_hs || w_hs || ar_hs || resp_hs;
    assign addr_done = req_write_q ? ((aw_done_q || aw_hs) && (w_done_q || w_hs)) : ar_hs;
    assign tmo_hit   = (TIMEOUT_CYCLES != 0) && !any_hs && (tmo_q == TO_LAST);

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) state_q <= S_IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (ADDR_TO_PERI_VALID) state_d = (in_clint || (req_mask == '0)) ? S_DONE : S_ADDR;
            S_ADDR: begin
                if (tmo_hit)        state_d = S_DONE;
                else if (addr_done) state_d = S_RESP;
            end
            S_RESP: begin
                if (tmo_hit)      state_d = S_DONE;
                else if (resp_hs) state_d = (resp_err || (mask_rest == '0)) ? S_DONE : S_ADDR;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_strb_q  <= '0;
            req_write_q <= 1'b0;
            req_word_q  <= 1'b0;
            mask_q      <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            tmo_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (ADDR_TO_PERI_VALID) begin
                    req_addr_q  <= ADDR_TO_PERI[C_M_AXI_ADDR_WIDTH-1:0];
                    req_data_q  <= DATA_TO_PERI;
                    req_strb_q  <= WSTRB;
                    req_write_q <= WRITE_TO_PERI;
                    req_word_q  <= PERI_WORD_ACCESS;
                    mask_q      <= in_clint ? '0 : req_mask;
                    rdata_q     <= in_clint ? CPU_DATA_WIDTH'(clint_rdata) : '0;
                    err_q       <= 1'b0;
                    aw_done_q   <= 1'b0;
                    w_done_q    <= 1'b0;
                    tmo_q       <= '0;
                end
                S_ADDR: begin
                    aw_done_q <= aw_done_q | aw_hs;
                    w_done_q  <= w_done_q | w_hs;
                    tmo_q     <= any_hs ? '0 : tmo_q + 32'd1;
                    if (tmo_hit) err_q <= 1'b1;
                end
                S_RESP: begin
                    tmo_q <= any_hs ? '0 : tmo_q + 32'd1;
                    if (tmo_hit) err_q <= 1'b1;
                    if (resp_hs) begin
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        if (resp_err) begin
                            err_q <= 1'b1;
                        end else begin
                            mask_q <= mask_rest;
                            if (!req_write_q) rdata_q[slot*C_M_AXI_DATA_WIDTH +: C_M_AXI_DATA_WIDTH] <= M_AXI_RDATA;
                        end
                    end
                end
                S_DONE: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        M_AXI_AWADDR         = '0;
        M_AXI_AWVALID        = 1'b0;
        M_AXI_WDATA          = '0;
        M_AXI_WSTRB          = '0;
        M_AXI_WVALID         = 1'b0;
        M_AXI_BREADY         = 1'b0;
        M_AXI_ARADDR         = '0;
        M_AXI_ARVALID        = 1'b0;
        M_AXI_RREADY         = 1'b0;
        DATA_FROM_PERI_READY = 1'b0;
        DATA_FROM_PERI       = '0;
        PERI_ERROR           = 1'b0;
        M_AXI_AWPROT         = '0;
        M_AXI_ARPROT         = '0;
        MTIP                 = mtip_q;
        MSIP                 = msip_q;
        case (state_q)
            S_ADDR: begin
                if (req_write_q) begin
                    M_AXI_AWVALID = !aw_done_q;
                    M_AXI_WVALID  = !w_done_q;
                    M_AXI_AWADDR  = beat_addr;
                    M_AXI_WDATA   = beat_wdata;
                    M_AXI_WSTRB   = beat_wstrb;
                end else begin
                    M_AXI_ARVALID = 1'b1;
                    M_AXI_ARADDR  = beat_addr;
                end
            end
            S_RESP: begin
                M_AXI_BREADY = req_write_q;
                M_AXI_RREADY = !req_write_q;
            end
            S_DONE: begin
                DATA_FROM_PERI_READY = 1'b1;
                DATA_FROM_PERI       = rdata_q;
                PERI_ERROR           = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_clint_axi_peripheral_bridge.sv
// Directed bench for clint_axi_peripheral_bridge: CLINT access and timer, AXI beat plan,
// error response, timeout recovery and asynchronous reset, against a small AXI slave model.
module tb_clint_axi_peripheral_bridge;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        addr_valid, wr, word;
    logic [63:0] addr, wdata;
    logic [7:0]  wstrb;
    logic        ready, perr;
    logic [63:0] rdata_o;
    logic [31:0] awaddr, araddr, wdata_ax, rdata_ax;
    logic [3:0]  wstrb_ax;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp, mtip, msip;

    clint_axi_peripheral_bridge #(
        .C_M_AXI_ADDR_WIDTH(32),
        .C_M_AXI_DATA_WIDTH(32),
        .CPU_DATA_WIDTH(64),
        .CLINT_BASE(32'h0200_0000),
        .N_HARTS(2),
        .MTIME_DIV(8),
        .TIMEOUT_CYCLES(15)
    ) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .ADDR_TO_PERI_VALID(addr_valid), .ADDR_TO_PERI(addr), .DATA_TO_PERI(wdata),
        .WSTRB(wstrb), .WRITE_TO_PERI(wr), .PERI_WORD_ACCESS(word),
        .DATA_FROM_PERI_READY(ready), .DATA_FROM_PERI(rdata_o), .PERI_ERROR(perr),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata_ax), .M_AXI_WSTRB(wstrb_ax), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata_ax), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
        .MTIP(mtip), .MSIP(msip)
    );

    // AXI4-Lite slave model: always-ready AW/W, configurable ARREADY and BRESP, one-cycle responses.
    logic        arready_en;
    logic [1:0]  bresp_cfg;
    logic        s_rvalid, s_bvalid, aw_got, w_got;
    logic [31:0] s_rdata, last_awaddr, last_wdata;
    logic [3:0]  last_wstrb;
    int          ar_cnt, aw_cnt, cyc;

    assign arready = arready_en;
    assign awready = 1'b1;
    assign wready  = 1'b1;
    assign rvalid  = s_rvalid;
    assign rdata_ax = s_rdata;
    assign rresp   = 2'b00;
    assign bvalid  = s_bvalid;
    assign bresp   = bresp_cfg;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h1000_0000: return 32'hDEAD_BEEF;
            32'h1000_0004: return 32'hCAFE_F00D;
            default:       return a ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s_rvalid <= 1'b0; s_bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
            s_rdata <= '0; last_awaddr <= '0; last_wdata <= '0; last_wstrb <= '0;
            ar_cnt <= 0; aw_cnt <= 0;
        end else begin
            if (s_rvalid && rready) s_rvalid <= 1'b0;
            if (arvalid && arready) begin
                ar_cnt   <= ar_cnt + 1;
                s_rvalid <= 1'b1;
                s_rdata  <= mem_word(araddr);
            end
            if (s_bvalid && bready) s_bvalid <= 1'b0;
            if (awvalid && awready) begin
                aw_cnt <= aw_cnt + 1; last_awaddr <= awaddr; aw_got <= 1'b1;
            end
            if (wvalid && wready) begin
                last_wdata <= wdata_ax; last_wstrb <= wstrb_ax; w_got <= 1'b1;
            end
            if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
                s_bvalid <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Issues a one-cycle request and waits (bounded) for READY; lat counts cycles after acceptance.
    task automatic do_req(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                          input logic w, input logic wd,
                          output logic [63:0] rd, output logic er, output int lat);
        @(negedge clk);
        addr = a; wdata = d; wstrb = s; wr = w; word = wd; addr_valid = 1'b1;
        @(negedge clk);
        addr_valid = 1'b0;
        lat = 1;
        while (!ready && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("ready_seen", {63'b0, ready}, 64'd1);
        rd = rdata_o;
        er = perr;
    endtask

    logic [63:0] rd;
    logic        er;
    int          lat, a0, w0;

    initial begin
        addr_valid = 1'b0; addr = '0; wdata = '0; wstrb = '0; wr = 1'b0; word = 1'b0;
        arready_en = 1'b1; bresp_cfg = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_ready",   {63'b0, ready}, 64'd0);
        check("rst_arvalid", {63'b0, arvalid}, 64'd0);
        check("rst_awvalid", {63'b0, awvalid}, 64'd0);
        check("rst_irq",     {60'b0, mtip, msip}, 64'd0);
        check("rst_data",    rdata_o, 64'd0);
        rst = 1'b0;

        // CLINT: mtimecmp[0] = 0x100, read back
        a0 = ar_cnt; w0 = aw_cnt;
        do_req(64'h0200_4000, 64'h100, 8'hFF, 1'b1, 1'b0, rd, er, lat);
        check("cmp_wr_lat", 64'(lat), 64'd1);
        check("cmp_wr_err", {63'b0, er}, 64'd0);
        do_req(64'h0200_4000, 64'h0, 8'h00, 1'b0, 1'b0, rd, er, lat);
        check("cmp_rd_data", rd, 64'h100);
        check("cmp_rd_lat", 64'(lat), 64'd1);
        @(negedge clk);
        check("ready_pulse_end", {63'b0, ready}, 64'd0);
        check("data_cleared", rdata_o, 64'd0);
        check("clint_no_axi", 64'((ar_cnt - a0) + (aw_cnt - w0)), 64'd0);

        // msip[1] via word write on upper lane
        do_req(64'h0200_0004, 64'h0000_0001_0000_0000, 8'hF0, 1'b1, 1'b1, rd, er, lat);
        check("msip_out", {62'b0, msip}, 64'h2);
        do_req(64'h0200_0004, 64'h0, 8'h00, 1'b0, 1'b1, rd, er, lat);
        check("msip_rd", rd, 64'h0000_0001_0000_0000);

        // Timer: mtime reaches 0x100 after 2048 edges, MTIP registered one edge later
        while (cyc < 2047) @(negedge clk);
        check("mtip_before", {62'b0, mtip}, 64'd0);
        while (cyc < 2051) @(negedge clk);
        check("mtip_after", {62'b0, mtip}, 64'h1);

        // Doubleword read over two 32-bit beats
        a0 = ar_cnt;
        do_req(64'h1000_0000, 64'h0, 8'h00, 1'b0, 1'b0, rd, er, lat);
        check("dw_rd_data", rd, 64'hCAFE_F00D_DEAD_BEEF);
        check("dw_rd_ar", 64'(ar_cnt - a0), 64'd2);
        check("dw_rd_err", {63'b0, er}, 64'd0);
        check("dw_rd_lat", 64'(lat), 64'd5);

        // Word read on upper lane
        do_req(64'h1000_0004, 64'h0, 8'h00, 1'b0, 1'b1, rd, er, lat);
        check("w_rd_data", rd, 64'hCAFE_F00D_0000_0000);
        check("w_rd_lat", 64'(lat), 64'd3);

        // Doubleword write with only upper strobes: single beat at +4
        w0 = aw_cnt;
        do_req(64'h1000_0000, 64'h1122_3344_5566_7788, 8'hF0, 1'b1, 1'b0, rd, er, lat);
        check("skip_aw_cnt", 64'(aw_cnt - w0), 64'd1);
        check("skip_awaddr", 64'(last_awaddr), 64'h1000_0004);
        check("skip_wstrb", 64'(last_wstrb), 64'hF);
        check("skip_wdata", 64'(last_wdata), 64'h1122_3344);
        check("skip_lat", 64'(lat), 64'd3);

        // All strobes zero: completes without AXI traffic
        w0 = aw_cnt;
        do_req(64'h1000_0040, 64'h0, 8'h00, 1'b1, 1'b0, rd, er, lat);
        check("nostrb_lat", 64'(lat), 64'd1);
        check("nostrb_aw", 64'(aw_cnt - w0), 64'd0);

        // SLVERR on beat 0 aborts beat 1
        bresp_cfg = 2'b10;
        w0 = aw_cnt;
        do_req(64'h1000_0020, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF, 1'b1, 1'b0, rd, er, lat);
        check("berr_err", {63'b0, er}, 64'd1);
        check("berr_aw_cnt", 64'(aw_cnt - w0), 64'd1);
        check("berr_awaddr", 64'(last_awaddr), 64'h1000_0020);
        bresp_cfg = 2'b00;

        // Timeout with ARREADY stuck low, then normal recovery
        arready_en = 1'b0;
        do_req(64'h1000_0008, 64'h0, 8'h00, 1'b0, 1'b1, rd, er, lat);
        check("tmo_lat", 64'(lat), 64'd16);
        check("tmo_err", {63'b0, er}, 64'd1);
        check("tmo_arvalid", {63'b0, arvalid}, 64'd0);
        arready_en = 1'b1;
        do_req(64'h1000_0000, 64'h0, 8'h00, 1'b0, 1'b1, rd, er, lat);
        check("recov_data", rd, 64'h0000_0000_DEAD_BEEF);
        check("recov_err", {63'b0, er}, 64'd0);

        // Asynchronous reset in the middle of a stalled read
        arready_en = 1'b0;
        @(negedge clk);
        addr = 64'h1000_0010; wr = 1'b0; word = 1'b1; addr_valid = 1'b1;
        @(negedge clk);
        addr_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_arvalid", {63'b0, arvalid}, 64'd1);
        check("pre_rst_msip", {62'b0, msip}, 64'h2);
        #2 rst = 1'b1;
        #1;
        check("async_arvalid", {63'b0, arvalid}, 64'd0);
        check("async_msip", {62'b0, msip}, 64'd0);
        check("async_ready", {63'b0, ready}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        arready_en = 1'b1;
        do_req(64'h0200_BFF8, 64'h0, 8'h00, 1'b0, 1'b0, rd, er, lat);
        check("mtime_after_rst", rd, 64'd0);
        do_req(64'h0200_4000, 64'h0, 8'h00, 1'b0, 1'b0, rd, er, lat);
        check("cmp_after_rst", rd, 64'hFFFF_FFFF_FFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
